// File: rtl/ro_meter_pkg.sv
// ro_meter_pkg: shared FSM state type and default widths for the ring-oscillator frequency meter.
package ro_meter_pkg;
  localparam int RO_GATE_W = 16;
  localparam int RO_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_e;
endpackage

// File: rtl/ro_edge_sync.sv
// ro_edge_sync: 2-flop synchronizer plus a third flop giving a one-cycle pulse per rising edge of async_in.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);
  logic [2:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[1:0], async_in};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: counts synchronized ro_in rising edges over a gate window of system clocks.
// Define RO_CONT_EN to add the cont port for back-to-back continuous measurement.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int GATE_W = RO_GATE_W,
  parameter int CNT_W  = RO_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ro_in,
  input  logic              start,
`ifdef RO_CONT_EN
  input  logic              cont,
`endif
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);
  state_e state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d, lat_q, lat_d;
  logic [CNT_W-1:0] edge_q, edge_d, count_q, count_d;
  logic ovf_q, ovf_d, overflow_q, overflow_d;
  logic rise, cont_w;
`ifdef RO_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif
  ro_edge_sync u_sync (.clk(clk), .rst_n(rst_n), .async_in(ro_in), .rise(rise));
  always_comb begin
    state_d = state_q;
    gate_d = gate_q;
    lat_d = lat_q;
    edge_d = edge_q;
    ovf_d = ovf_q;
    count_d = count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (start) begin
        lat_d = gate_cycles;
        gate_d = gate_cycles;
        edge_d = '0;
        ovf_d = 1'b0;
        state_d = (gate_cycles == '0) ? DONE : ARM;
      end
      ARM: begin
        gate_d = lat_q;
        edge_d = '0;
        ovf_d = 1'b0;
        state_d = MEASURE;
      end
      MEASURE: begin
        gate_d = gate_q - GATE_W'(1);
        if (rise) begin
          if (&edge_q) ovf_d = 1'b1;
          else edge_d = edge_q + CNT_W'(1);
        end
        state_d = (gate_q == GATE_W'(1)) ? DONE : MEASURE;
      end
      DONE: state_d = (cont_w && lat_q != '0) ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
    // Results move to the outputs on entry to DONE so they are valid with the pulse.
    if (state_d == DONE && state_q != DONE) begin
      count_d = edge_d;
      overflow_d = ovf_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gate_q <= '0;
      lat_q <= '0;
      edge_q <= '0;
      ovf_q <= 1'b0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q <= gate_d;
      lat_q <= lat_d;
      edge_q <= edge_d;
      ovf_q <= ovf_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign count = count_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: scoreboard bench; a periodic ro_in model predicts each window's edge count.
module tb_ro_freq_meter;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst_n = 0, ro_in = 0, start = 0;
  logic [15:0] gate_cycles = '0;
  logic busy, done, overflow;
  logic [CW-1:0] count;
`ifdef RO_CONT_EN
  logic cont = 0;
`endif
  int cyc = 0, checks = 0, errors = 0;
  int per = 10, hi = 5, ph = 0;
  typedef struct {int cyc; int cnt; int ovf; int blen;} exp_t;
  exp_t sbq[$];
  int brun = 0, hold_cnt = 0, hold_ovf = 0;

  ro_freq_meter #(.GATE_W(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .start(start),
`ifdef RO_CONT_EN
    .cont(cont),
`endif
    .gate_cycles(gate_cycles), .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ro_in level as sampled at clock edge k
  function automatic bit ro_fn(int k);
    return ((k + ph) % per) < hi;
  endfunction
  always @(negedge clk) ro_in = ro_fn(cyc + 1);

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endfunction

  // Window counts rises of ro_in seen at edges n..n+G-1, where n is the edge accepting start.
  task automatic push_exp(input int n, input int g);
    exp_t e;
    int c = 0;
    for (int k = n; k < n + g; k++) if (ro_fn(k) && !ro_fn(k - 1)) c++;
    e.cnt = (c > CMAX) ? CMAX : c;
    e.ovf = (c > CMAX) ? 1 : 0;
    e.cyc = (g == 0) ? n : n + g + 1;
    e.blen = (g == 0) ? 1 : g + 2;
    sbq.push_back(e);
  endtask

  task automatic do_start(input int g, output int n);
    @(negedge clk);
    start = 1;
    gate_cycles = 16'(g);
    n = cyc + 1;
    push_exp(n, g);
    @(negedge clk);
    start = 0;
    gate_cycles = 16'($urandom);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sbq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_ro(input int p, input int h, input int f);
    per = p;
    hi = h;
    ph = f;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      brun = 0;
      hold_cnt = 0;
      hold_ovf = 0;
    end else begin
      if (busy) brun++;
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 cyc=%0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("count", int'(count), e.cnt);
          chk("overflow", int'(overflow), e.ovf);
          chk("busy_len", brun, e.blen);
          hold_cnt = e.cnt;
          hold_ovf = e.ovf;
        end
        brun = 0;
      end else begin
        chk("hold_count", int'(count), hold_cnt);
        chk("hold_ovf", int'(overflow), hold_ovf);
      end
    end
  end

  initial begin
    int n, g;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge clk) rst_n = 1;
    set_ro(10, 5, 3);
    do_start(100, n);
    wait_idle();
    set_ro(4, 2, 1);
    do_start(100, n);
    wait_idle();
    do_start(20, n);
    wait_idle();
    do_start(0, n);
    wait_idle();
    set_ro(7, 3, 2);
    do_start(100, n);
    wait_cyc(n + 5);
    pulse_start();
    wait_cyc(n + 50);
    pulse_start();
    wait_cyc(n + 101);
    pulse_start();
    wait_idle();
    do_start(80, n);
    wait_cyc(n + 30);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ovf", int'(overflow), 0);
    sbq.delete();
    @(posedge clk);
    #2 rst_n = 1;
    repeat (6) @(negedge clk);
    do_start(50, n);
    wait_idle();
    for (int i = 0; i < 25; i++) begin
      int p = $urandom_range(4, 30);
      set_ro(p, $urandom_range(2, p - 2), $urandom_range(0, p - 1));
      g = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 90);
      do_start(g, n);
      wait_idle();
    end
`ifdef RO_CONT_EN
    set_ro(8, 4, 0);
    cont = 1;
    do_start(40, n);
    push_exp(n + 42, 40);
    push_exp(n + 84, 40);
    wait_cyc(n + 89);
    cont = 0;
    wait_idle();
    chk("cont_idle_busy", int'(busy), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
- Downstream consumer of the 5-stage inverter ring oscillator cell.
- Measures oscillator frequency by counting rising edges of the oscillator output over a programmable window of system clock cycles.
- Result is handed off with a one-cycle done pulse and held until the next measurement starts.
- Oscillator output arrives asynchronously, pre-divided so that f_ro < f_clk/4.

Parameters:
- GATE_W, 16, width of the gate-window length (system clock cycles).
- CNT_W, 16, width of the edge-count result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ro_in  input  1  ring-oscillator output (asynchronous to clk).
- start  input  1  single-cycle request to begin a measurement.
- gate_cycles  input  GATE_W  window length; sampled only on an accepted start.
- busy  output  1  high from accepted start until done, inclusive.
- done  output  1  one-cycle pulse; count and overflow are valid from this cycle.
- count  output  CNT_W  rising edges detected inside the window.
- overflow  output  1  edge count exceeded 2^CNT_W-1 during the window.

Behaviour:
- Reset (async, rst_n low): state IDLE, busy=0, done=0, count=0, overflow=0, synchronizer flops=0, gate counter=0.
- Synchronizer: ro_in passes through 2 flops, then a third flop for edge detect.
  - rise = s2 & ~s3.
  - The synchronizer runs continuously in every state.
- FSM states and transitions:
  - IDLE: start=1 latches gate_cycles into the gate counter and goes to ARM (gate_cycles!=0) or DONE (gate_cycles==0).
  - ARM (1 cycle): clears the edge counter and overflow, then goes to MEASURE.
  - MEASURE: each cycle, gate counter decrements and rise increments the edge counter. When the gate counter reaches 1 in this cycle, go to DONE. The window is exactly G cycles of MEASURE.
  - DONE (1 cycle): done=1, count/overflow registered from the edge counter, then return to IDLE.
  - For gate_cycles==0: count=0, overflow=0.
- Latency: start accepted at cycle t -> ARM at t+1 -> MEASURE at t+2..t+1+G -> done at t+2+G.
- busy is asserted from t+1 through the done cycle.
- Edge counter saturates at 2^CNT_W-1. The first increment attempted at saturation sets overflow, which stays set until the next ARM.
- count/overflow hold their value in IDLE until the next DONE. They are not cleared by start.
- start while busy: ignored, no queuing. start in the DONE cycle is also ignored.
- Reset mid-measurement: immediate return to IDLE with all outputs 0, and no done pulse.
- Edges arriving faster than f_clk/4 are out of spec. Counts may be low, with no error flag.

Optional Feature:
- Macro RO_CONT_EN.
- Defined:
  - Adds input port cont (1 bit).
  - If cont=1 in DONE, the FSM goes to ARM instead of IDLE, reloading the gate counter from the gate_cycles value latched at the last accepted start.
  - done pulses every G+2 cycles, and busy stays high.
  - Dropping cont finishes the current window, then goes to IDLE.
- Undefined: no cont port; single-shot only, as above.

Decomposition:
- Package ro_meter_pkg:
  - state enum {IDLE, ARM, MEASURE, DONE} (2 bits).
  - Default constants RO_GATE_W=16 and RO_CNT_W=16.
- Sub-module ro_edge_sync: 3-flop synchronizer plus rising-edge pulse, with ports clk, rst_n, async_in, rise.

Test Plan:
- ro_in period 10 clk, gate_cycles=100, start pulse -> done 102 cycles after start; count=10, overflow=0, busy high for 102 cycles.
- CNT_W=4, ro_in period 4 clk, gate_cycles=100 -> count=15, overflow=1; next run with gate_cycles=20 -> count=5, overflow=0.
- gate_cycles=0, start -> done 1 cycle after start (DONE reached directly from IDLE, no ARM), count=0; ro_in toggling has no effect.
- start re-asserted at cycles 5 and 50 during a 100-cycle window -> single done, count from the first window only, no second measurement.
- rst_n low for 1 cycle mid-MEASURE -> busy=0, count=0 immediately; no done pulse; a fresh start afterward measures correctly.
- RO_CONT_EN, cont=1, gate_cycles=40, ro_in period 8 -> done pulses every 42 cycles with count=5; cont dropped -> one more done, then IDLE.
